netlist_bist_ctrl: RTL and testbench

NETLIST_BIST_CTRL -- requirements
Module: netlist_bist_ctrl

---
 rtl/netlist_bist_ctrl.sv | 152 +++++++++++++++
 tb/tb_netlist_bist_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/netlist_bist_ctrl.sv
// netlist_bist_ctrl
// -----------------
// Built-in self-test controller for a small combinational netlist with
// 14 inputs and 8 outputs. A run drives N_PAT pseudo-random patterns from a
// 14-bit LFSR onto the netlist inputs. Each pattern is held for SETTLE+1
// cycles. On the last cycle of each pattern the netlist response is folded
// into a 16-bit MISR. At the end of the run the MISR is compared with a
// golden signature.
//
// Parameters
//   N_PAT      patterns per run (1..65535)
//   SETTLE     wait cycles between applying a pattern and capturing (0..15)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   start      level-sampled run request, accepted only in IDLE
//   seed       stimulus LFSR seed, sampled with start (0 is replaced by 1)
//   golden_sig expected signature, sampled with start
//   stim       registered drive to netlist inputs pi00..pi13 (stim[0]=pi00)
//   rsp        netlist outputs po0..po7 (rsp[0]=po0)
//   busy       high while a run is in progress
//   done       one-cycle pulse after the last capture
//   pass       final signature matched golden_sig; held until next start
//   signature  current MISR contents

module netlist_bist_ctrl #(
    parameter int unsigned N_PAT  = 1024,
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] seed,
    input  logic [15:0] golden_sig,
    output logic [13:0] stim,
    input  logic [7:0]  rsp,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam logic [15:0] LP_LAST   = 16'(N_PAT - 1);
    localparam logic [3:0]  LP_SETTLE = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [13:0] r_stim;
    logic [15:0] r_misr;
    logic [15:0] r_count;
    logic [3:0]  r_settle;
    logic [15:0] r_golden;
    logic        r_pass;

    logic        w_accept;
    logic        w_capture;
    logic        w_lastCapture;
    logic [15:0] w_misrNext;
    logic [13:0] w_stimNext;
    logic [13:0] w_seedSafe;

    // A capture happens on the first RUN edge where the settle countdown
    // has already reached zero; the last one is the capture of pattern N_PAT-1.
    assign w_accept      = (r_state == S_IDLE) && start;
    assign w_capture     = (r_state == S_RUN) && (r_settle == 4'd0);
    assign w_lastCapture = w_capture && (r_count == LP_LAST);

    // An all-zero seed would lock the LFSR at zero, so it is forced to 1.
    assign w_seedSafe = (seed == 14'd0) ? 14'h0001 : seed;

    assign w_stimNext = {r_stim[12:0], r_stim[13] ^ r_stim[12] ^ r_stim[11] ^ r_stim[1]};
    assign w_misrNext = {r_misr[14:0], r_misr[15] ^ r_misr[14] ^ r_misr[12] ^ r_misr[3]}
                        ^ {8'h00, rsp};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: start is only looked at in IDLE, so a request made
    // during RUN or DONE is dropped rather than queued.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (start) w_nextState = S_RUN;
            S_RUN:   if (w_lastCapture) w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: LFSR, MISR, pattern and settle counters, golden latch.
    // Outside RUN everything holds, so results stay visible after the run.
    // On the final capture stim is left on the last pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stim   <= 14'd0;
            r_misr   <= 16'd0;
            r_count  <= 16'd0;
            r_settle <= 4'd0;
            r_golden <= 16'd0;
            r_pass   <= 1'b0;
        end else if (w_accept) begin
            r_stim   <= w_seedSafe;
            r_misr   <= 16'd0;
            r_count  <= 16'd0;
            r_settle <= LP_SETTLE;
            r_golden <= golden_sig;
            r_pass   <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (r_settle != 4'd0) begin
                r_settle <= r_settle - 4'd1;
            end else if (w_lastCapture) begin
                r_misr <= w_misrNext;
                r_pass <= (w_misrNext == r_golden);
            end else begin
                r_misr   <= w_misrNext;
                r_stim   <= w_stimNext;
                r_count  <= r_count + 16'd1;
                r_settle <= LP_SETTLE;
            end
        end
    end

    assign stim      = r_stim;
    assign signature = r_misr;
    assign pass      = r_pass;

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// tb_netlist_bist_ctrl
// --------------------
// Self-checking bench for netlist_bist_ctrl. Four instances with different
// parameters share clk and rst; each has its own start/seed/golden/rsp:
//   0: N_PAT=4 SETTLE=1  seed 1, rsp 0     (stimulus stepping)
//   1: N_PAT=2 SETTLE=1  seed 1, rsp FF    (signature match)
//   2: N_PAT=1 SETTLE=1  seed 5, rsp FF    (reset abort, mismatch)
//   3: N_PAT=3 SETTLE=0  seed 0, rsp 0     (zero seed, held start)
// A table of per-edge expected values covers the straight runs. Hand-written
// sequences cover reset, reset mid-run and start held high.

module tb_netlist_bist_ctrl;

    typedef struct {
        int          sel;
        bit          startRun;
        logic [13:0] expStim;
        logic [15:0] expSig;
        logic        expBusy;
        logic        expDone;
        logic        expPass;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        startI [4];
    logic [13:0] seedI  [4];
    logic [15:0] goldI  [4];
    logic [7:0]  rspI   [4];
    logic [13:0] stimO  [4];
    logic        busyO  [4];
    logic        doneO  [4];
    logic        passO  [4];
    logic [15:0] sigO   [4];

    int errCount   = 0;
    int checkCount = 0;

    vec_t vecs[$];

    netlist_bist_ctrl #(.N_PAT(4), .SETTLE(1)) dutA (
        .clk(clk), .rst(rst), .start(startI[0]), .seed(seedI[0]),
        .golden_sig(goldI[0]), .stim(stimO[0]), .rsp(rspI[0]),
        .busy(busyO[0]), .done(doneO[0]), .pass(passO[0]), .signature(sigO[0])
    );

    netlist_bist_ctrl #(.N_PAT(2), .SETTLE(1)) dutB (
        .clk(clk), .rst(rst), .start(startI[1]), .seed(seedI[1]),
        .golden_sig(goldI[1]), .stim(stimO[1]), .rsp(rspI[1]),
        .busy(busyO[1]), .done(doneO[1]), .pass(passO[1]), .signature(sigO[1])
    );

    netlist_bist_ctrl #(.N_PAT(1), .SETTLE(1)) dutC (
        .clk(clk), .rst(rst), .start(startI[2]), .seed(seedI[2]),
        .golden_sig(goldI[2]), .stim(stimO[2]), .rsp(rspI[2]),
        .busy(busyO[2]), .done(doneO[2]), .pass(passO[2]), .signature(sigO[2])
    );

    netlist_bist_ctrl #(.N_PAT(3), .SETTLE(0)) dutD (
        .clk(clk), .rst(rst), .start(startI[3]), .seed(seedI[3]),
        .golden_sig(goldI[3]), .stim(stimO[3]), .rsp(rspI[3]),
        .busy(busyO[3]), .done(doneO[3]), .pass(passO[3]), .signature(sigO[3])
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it before sampling.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic compareVal(input string name, input logic [15:0] act, input logic [15:0] req);
        checkCount++;
        if (act !== req) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [13:0] eStim,
                               input logic [15:0] eSig, input logic eBusy, input logic eDone,
                               input logic ePass);
        compareVal({name, ".stim"}, 16'(stimO[sel]), 16'(eStim));
        compareVal({name, ".sig"},  sigO[sel],       eSig);
        compareVal({name, ".busy"}, 16'(busyO[sel]), 16'(eBusy));
        compareVal({name, ".done"}, 16'(doneO[sel]), 16'(eDone));
        compareVal({name, ".pass"}, 16'(passO[sel]), 16'(ePass));
    endtask

    // One table row is one rising edge. A startRun row raises start for that
    // edge only, so the start edge of a run is edge 0.
    task automatic applyStimulus(input vec_t v);
        if (v.startRun) startI[v.sel] = 1'b1;
        stepEdge();
        startI[v.sel] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) startI[i] = 1'b0;
        seedI[0] = 14'h0001; rspI[0] = 8'h00; goldI[0] = 16'h0000;
        seedI[1] = 14'h0001; rspI[1] = 8'hFF; goldI[1] = 16'h0100;
        seedI[2] = 14'h0005; rspI[2] = 8'hFF; goldI[2] = 16'h0000;
        seedI[3] = 14'h0000; rspI[3] = 8'h00; goldI[3] = 16'h0000;

        // The stimulus LFSR taps bit 1, so 0x0002 advances to 0x0005 and
        // then 0x000A (0x0005 has bit 1 clear). With SETTLE=1 a pattern
        // lives two edges and the final capture leaves stim unchanged.
        //                sel start stim      sig        busy  done  pass
        vecs.push_back('{0, 1'b1, 14'h0001, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 14'h0001, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 14'h0002, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 14'h0002, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 14'h0005, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 14'h0005, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 14'h000A, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 14'h000A, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 14'h000A, 16'h0000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{0, 1'b0, 14'h000A, 16'h0000, 1'b0, 1'b0, 1'b1});
        // rsp=FF: first capture gives 0x00FF; second has feedback 1 from
        // bit 3, giving 0x01FF ^ 0x00FF = 0x0100. Done after edge 4.
        vecs.push_back('{1, 1'b1, 14'h0001, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1, 1'b0, 14'h0001, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1, 1'b0, 14'h0002, 16'h00FF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1, 1'b0, 14'h0002, 16'h00FF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1, 1'b0, 14'h0002, 16'h0100, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1, 1'b0, 14'h0002, 16'h0100, 1'b0, 1'b0, 1'b1});
        // Zero seed becomes 1, SETTLE=0: a new pattern every edge, done after edge 3.
        vecs.push_back('{3, 1'b1, 14'h0001, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3, 1'b0, 14'h0002, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3, 1'b0, 14'h0005, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3, 1'b0, 14'h0005, 16'h0000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{3, 1'b0, 14'h0005, 16'h0000, 1'b0, 1'b0, 1'b1});

        // Reset values, checked while rst is held and before any edge.
        #3;
        checkOutput("rstA", 0, 14'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("rstC", 2, 14'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        #9;
        rst = 1'b0;
        stepEdge();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].sel, vecs[i].expStim,
                        vecs[i].expSig, vecs[i].expBusy, vecs[i].expDone, vecs[i].expPass);
        end

        // Reset in the middle of a run: everything clears at once, no done follows.
        startI[2] = 1'b1;
        stepEdge();
        startI[2] = 1'b0;
        compareVal("abort.busyBefore", 16'(busyO[2]), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort.inRst", 2, 14'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            stepEdge();
            compareVal($sformatf("abort.noDone%0d", k), 16'(doneO[2]), 16'd0);
            compareVal($sformatf("abort.idle%0d", k),   16'(busyO[2]), 16'd0);
        end

        // Fresh run after the abort, golden 0 -> mismatch, single done pulse.
        startI[2] = 1'b1;
        stepEdge();
        startI[2] = 1'b0;
        checkOutput("miss.e0", 2, 14'h0005, 16'h0000, 1'b1, 1'b0, 1'b0);
        stepEdge();
        stepEdge();
        checkOutput("miss.e2", 2, 14'h0005, 16'h00FF, 1'b0, 1'b1, 1'b0);
        stepEdge();
        checkOutput("miss.e3", 2, 14'h0005, 16'h00FF, 1'b0, 1'b0, 1'b0);

        // Same run with the matching golden value; pass must stay set in IDLE.
        goldI[2] = 16'h00FF;
        startI[2] = 1'b1;
        stepEdge();
        startI[2] = 1'b0;
        goldI[2] = 16'h0000;
        stepEdge();
        stepEdge();
        checkOutput("hit.e2", 2, 14'h0005, 16'h00FF, 1'b0, 1'b1, 1'b1);
        stepEdge();
        stepEdge();
        stepEdge();
        checkOutput("hit.sticky", 2, 14'h0005, 16'h00FF, 1'b0, 1'b0, 1'b1);

        // start held high throughout: no reload during RUN or DONE, the
        // DONE->IDLE edge ignores it, and the next IDLE edge starts again.
        startI[3] = 1'b1;
        stepEdge();
        compareVal("hold.e0.stim", 16'(stimO[3]), 16'h0001);
        stepEdge();
        compareVal("hold.e1.stim", 16'(stimO[3]), 16'h0002);
        stepEdge();
        stepEdge();
        compareVal("hold.e3.done", 16'(doneO[3]), 16'd1);
        stepEdge();
        compareVal("hold.e4.busy", 16'(busyO[3]), 16'd0);
        compareVal("hold.e4.done", 16'(doneO[3]), 16'd0);
        stepEdge();
        compareVal("hold.e5.busy", 16'(busyO[3]), 16'd1);
        compareVal("hold.e5.stim", 16'(stimO[3]), 16'h0001);
        compareVal("hold.e5.pass", 16'(passO[3]), 16'd0);
        startI[3] = 1'b0;
        stepEdge();
        stepEdge();
        stepEdge();
        compareVal("hold.e8.done", 16'(doneO[3]), 16'd1);
        stepEdge();
        compareVal("hold.e9.done", 16'(doneO[3]), 16'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
